riscv_v_logic_seq: RTL

- Multi-cycle sequencer that drives the combinational 128-bit vector bitwise unit (AND/OR/XOR, element-wise and reduction) across a register group of LMUL 1/2/4/8 registers, one 128-bit chunk per cycle.
- Sits between vector issue, which supplies the op descriptor and streams operand chunks, and writeback, which consumes the result chunks.
- For reductions, folds each chunk's reduced element into an internal accumulator and emits one scalar-element result at the end.

---
 rtl/riscv_v_pkg.sv | 33 +++
 rtl/riscv_v_logic_seq_acc.sv | 41 ++++
 rtl/riscv_v_logic_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/riscv_v_pkg.sv
// riscv_v_pkg: shared widths, op/state enums and the osize-to-bitmask helper
// for the vector logic sequencer.
package riscv_v_pkg;

    localparam int RISCV_V_DATA_WIDTH       = 128;
    localparam int RISCV_V_NUM_BYTES        = RISCV_V_DATA_WIDTH / 8;
    localparam int RISCV_V_NUM_VALID_OSIZES = 5;

    typedef enum logic [1:0] {
        LOGIC_AND = 2'd0,
        LOGIC_OR  = 2'd1,
        LOGIC_XOR = 2'd2
    } logic_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2
    } logic_seq_state_e;

    // Low-bit mask one element wide; anything that is not one-hot means 8 bits.
    function automatic logic [RISCV_V_DATA_WIDTH-1:0] osize_mask(
        input logic [RISCV_V_NUM_VALID_OSIZES-1:0] osize_vector
    );
        int w;
        w = osize_vector == 5'b00010 ? 16 :
            osize_vector == 5'b00100 ? 32 :
            osize_vector == 5'b01000 ? 64 :
            osize_vector == 5'b10000 ? 128 : 8;
        return {RISCV_V_DATA_WIDTH{1'b1}} >> (RISCV_V_DATA_WIDTH - w);
    endfunction

endpackage

// File: rtl/riscv_v_logic_seq_acc.sv
// riscv_v_logic_seq_acc: reduction accumulator with op fold and element masking.
//   clr          - flush: accumulator back to zero
//   init/init_op - new request: seed with all-ones (AND) or zero (OR/XOR)
//   fold         - accepted reduction chunk: acc <= acc_fold
//   acc_fold     - acc OP (data masked to element width), masked to element width
module riscv_v_logic_seq_acc
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
    parameter int NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  init,
    input  logic_op_e             init_op,
    input  logic                  fold,
    input  logic_op_e             op,
    input  logic [NUM_OSIZES-1:0] osize_vector,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] acc_fold
);

    logic [DATA_WIDTH-1:0] acc_q, acc_d, mask, masked;

    always_comb begin
        mask     = osize_mask(osize_vector);
        masked   = data & mask;
        acc_fold = (op == LOGIC_AND ? acc_q & masked :
                    op == LOGIC_OR  ? acc_q | masked : acc_q ^ masked) & mask;
        acc_d    = clr  ? '0 :
                   init ? (init_op == LOGIC_AND ? '1 : '0) :
                   fold ? acc_fold : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

endmodule

// File: rtl/riscv_v_logic_seq.sv
// riscv_v_logic_seq: walks a 1/2/4/8-register group through the 128-bit vector
// bitwise datapath one chunk per cycle.
//   req_*  - op descriptor from issue, accepted only in IDLE
//   op_*   - operand chunk stream, passed straight through to dp_srca/srcb/mask
//   dp_*   - datapath selects (registered) and operands; dp_result returns same cycle
//   res_*  - 1-deep result register to writeback; reductions emit one element
//   flush  - synchronous abort, beats any simultaneous handshake
module riscv_v_logic_seq
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
    parameter int NUM_BYTES  = DATA_WIDTH / 8,
    parameter int NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic                  req_is_reduct,
    input  logic [1:0]            req_lmul_log2,
    input  logic [NUM_OSIZES-1:0] req_osize_vector,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [DATA_WIDTH-1:0] op_srca,
    input  logic [DATA_WIDTH-1:0] op_srcb,
    input  logic [NUM_BYTES-1:0]  op_mask,
    output logic                  dp_is_and,
    output logic                  dp_is_or,
    output logic                  dp_is_xor,
    output logic                  dp_is_reduct,
    output logic [NUM_OSIZES-1:0] dp_osize_vector,
    output logic [DATA_WIDTH-1:0] dp_srca,
    output logic [DATA_WIDTH-1:0] dp_srcb,
    output logic [NUM_BYTES-1:0]  dp_mask,
    input  logic [DATA_WIDTH-1:0] dp_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_last,
    output logic                  busy
);

    logic_seq_state_e      state_q, state_d;
    logic_op_e             op_q, op_d, req_op_e;
    logic                  is_reduct_q, is_reduct_d;
    logic [NUM_OSIZES-1:0] osize_q, osize_d;
    logic [2:0]            remaining_q, remaining_d;
    logic                  res_valid_q, res_valid_d, res_last_q, res_last_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d, acc_fold;
    logic                  req_fire, op_fire, last;

    assign req_op_e  = req_op == 2'd0 ? LOGIC_AND : req_op == 2'd1 ? LOGIC_OR : LOGIC_XOR;
    assign busy      = state_q != SEQ_IDLE;
    assign req_ready = state_q == SEQ_IDLE && (!res_valid_q || res_ready);
    // Reductions never hold a result while in RUN, so they stream at full rate.
    assign op_ready  = state_q == SEQ_RUN && (is_reduct_q || !res_valid_q || res_ready);
    assign req_fire  = req_valid && req_ready && !flush;
    assign op_fire   = op_valid && op_ready && !flush;
    assign last      = remaining_q == 3'd0;

    assign dp_is_and       = busy && op_q == LOGIC_AND;
    assign dp_is_or        = busy && op_q == LOGIC_OR;
    assign dp_is_xor       = busy && op_q == LOGIC_XOR;
    assign dp_is_reduct    = busy && is_reduct_q;
    assign dp_osize_vector = osize_q;
    assign dp_srca         = op_srca;
    assign dp_srcb         = op_srcb;
    assign dp_mask         = op_mask;
    assign res_valid       = res_valid_q;
    assign res_data        = res_data_q;
    assign res_last        = res_last_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        is_reduct_d = is_reduct_q;
        osize_d     = osize_q;
        remaining_d = remaining_q;
        res_valid_d = res_valid_q && !res_ready;
        res_last_d  = res_last_q && !res_ready;
        res_data_d  = res_data_q;
        if (flush) begin
            state_d     = SEQ_IDLE;
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
        end else if (req_fire) begin
            state_d     = SEQ_RUN;
            op_d        = req_op_e;
            is_reduct_d = req_is_reduct;
            osize_d     = req_osize_vector;
            remaining_d = 3'((4'd1 << req_lmul_log2) - 4'd1);
        end else if (op_fire) begin
            remaining_d = last ? remaining_q : remaining_q - 3'd1;
            if (is_reduct_q) begin
                if (last) begin
                    state_d     = SEQ_DRAIN;
                    res_valid_d = 1'b1;
                    res_last_d  = 1'b1;
                    res_data_d  = acc_fold;
                end
            end else begin
                state_d     = last ? SEQ_IDLE : SEQ_RUN;
                res_valid_d = 1'b1;
                res_last_d  = last;
                res_data_d  = dp_result;
            end
        end else if (state_q == SEQ_DRAIN && res_ready) begin
            state_d = SEQ_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEQ_IDLE;
            op_q        <= LOGIC_AND;
            is_reduct_q <= 1'b0;
            osize_q     <= '0;
            remaining_q <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            is_reduct_q <= is_reduct_d;
            osize_q     <= osize_d;
            remaining_q <= remaining_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            res_data_q  <= res_data_d;
        end
    end

    riscv_v_logic_seq_acc #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_OSIZES(NUM_OSIZES)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clr         (flush),
        .init        (req_fire),
        .init_op     (req_op_e),
        .fold        (op_fire && is_reduct_q),
        .op          (op_q),
        .osize_vector(osize_q),
        .data        (dp_result),
        .acc_fold    (acc_fold)
    );

endmodule
